// File: rtl/keypad_entry.sv
// Keypad entry: debounces scanner presses into single key events, collects a decimal
// entry with backspace/enter, and converts it to binary one digit per cycle.
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned MAX_DIGITS      = 4,
    parameter int unsigned VALUE_W         = 14
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [3:0]                          key_code,
    input  logic                                key_pressed,
    output logic                                key_event,
    output logic [3:0]                          key_event_code,
    output logic [4*MAX_DIGITS-1:0]             entry_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]     digit_count,
    output logic                                busy,
    output logic                                entry_valid,
    output logic [VALUE_W-1:0]                  entry_value
);

    localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned IdxW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BcdW = 4 * MAX_DIGITS;

    localparam logic [3:0] KeyStar = 4'd10;
    localparam logic [3:0] KeyHash = 4'd11;

    typedef enum logic {DbWaitPress, DbWaitRelease} db_state_e;
    typedef enum logic {StEntry, StConvert} entry_state_e;

    db_state_e      db_state_q, db_state_d;
    logic [3:0]     cand_q, cand_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic [DbW-1:0] db_cnt_inc;
    logic           db_done;
    logic           qualifies;
    logic           key_event_q, key_event_d;
    logic [3:0]     key_event_code_q, key_event_code_d;

    entry_state_e       st_q, st_d;
    logic [BcdW-1:0]    bcd_q, bcd_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [VALUE_W-1:0] acc_q, acc_d, acc_step;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [3:0]         nibble;

    assign qualifies  = key_pressed && (key_code <= KeyHash);
    assign db_cnt_inc = db_cnt_q + DbW'(1);
    assign db_done    = (db_cnt_inc == DbW'(DEBOUNCE_CYCLES));

    always_comb begin
        db_state_d       = db_state_q;
        cand_d           = cand_q;
        db_cnt_d         = db_cnt_q;
        key_event_d      = 1'b0;
        key_event_code_d = key_event_code_q;
        case (db_state_q)
            DbWaitPress: begin
                if (qualifies && (key_code == cand_q)) begin
                    if (db_done) begin
                        key_event_d      = 1'b1;
                        key_event_code_d = cand_q;
                        db_cnt_d         = '0;
                        db_state_d       = DbWaitRelease;
                    end else begin
                        db_cnt_d = db_cnt_inc;
                    end
                end else begin
                    // Any break in a matching run restarts it on the new code.
                    cand_d   = key_code;
                    db_cnt_d = '0;
                end
            end
            DbWaitRelease: begin
                if (key_pressed) begin
                    db_cnt_d = '0;
                end else if (db_done) begin
                    db_cnt_d   = '0;
                    db_state_d = DbWaitPress;
                end else begin
                    db_cnt_d = db_cnt_inc;
                end
            end
            default: db_state_d = DbWaitPress;
        endcase
    end

    assign nibble   = bcd_q[{idx_q, 2'b00} +: 4];
    assign acc_step = (acc_q << 3) + (acc_q << 1) + VALUE_W'(nibble);

    always_comb begin
        st_d    = st_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        value_d = value_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (st_q)
            StEntry: begin
                if (key_event_q) begin
                    if (key_event_code_q <= 4'd9) begin
                        if (cnt_q != CntW'(MAX_DIGITS)) begin
                            bcd_d = (bcd_q << 4) | BcdW'(key_event_code_q);
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else if (key_event_code_q == KeyStar) begin
                        if (cnt_q != '0) begin
                            bcd_d = bcd_q >> 4;
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end else if (key_event_code_q == KeyHash) begin
                        if (cnt_q != '0) begin
                            st_d   = StConvert;
                            busy_d = 1'b1;
                            acc_d  = '0;
                            idx_d  = IdxW'(cnt_q - CntW'(1));
                        end
                    end
                end
            end
            StConvert: begin
                // Most significant digit first; nibble 0 is the final step.
                acc_d = acc_step;
                idx_d = idx_q - IdxW'(1);
                if (idx_q == '0) begin
                    valid_d = 1'b1;
                    value_d = acc_step;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    st_d    = StEntry;
                end
            end
            default: st_d = StEntry;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_state_q       <= DbWaitPress;
            cand_q           <= '0;
            db_cnt_q         <= '0;
            key_event_q      <= 1'b0;
            key_event_code_q <= '0;
            st_q             <= StEntry;
            bcd_q            <= '0;
            cnt_q            <= '0;
            idx_q            <= '0;
            acc_q            <= '0;
            value_q          <= '0;
            busy_q           <= 1'b0;
            valid_q          <= 1'b0;
        end else begin
            db_state_q       <= db_state_d;
            cand_q           <= cand_d;
            db_cnt_q         <= db_cnt_d;
            key_event_q      <= key_event_d;
            key_event_code_q <= key_event_code_d;
            st_q             <= st_d;
            bcd_q            <= bcd_d;
            cnt_q            <= cnt_d;
            idx_q            <= idx_d;
            acc_q            <= acc_d;
            value_q          <= value_d;
            busy_q           <= busy_d;
            valid_q          <= valid_d;
        end
    end

    assign key_event      = key_event_q;
    assign key_event_code = key_event_code_q;
    assign entry_bcd      = bcd_q;
    assign digit_count    = cnt_q;
    assign busy           = busy_q;
    assign entry_valid    = valid_q;
    assign entry_value    = value_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a per-cycle reference model of key events and the digit
// entry, compared every cycle, plus literal checks on the directed scenarios.
module tb_keypad_entry;

    localparam int DB = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  key_code;
    logic        key_pressed;
    logic        key_event;
    logic [3:0]  key_event_code;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic        busy;
    logic        entry_valid;
    logic [13:0] entry_value;

    keypad_entry #(
        .DEBOUNCE_CYCLES(DB),
        .MAX_DIGITS     (4),
        .VALUE_W        (14)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_code      (key_code),
        .key_pressed   (key_pressed),
        .key_event     (key_event),
        .key_event_code(key_event_code),
        .entry_bcd     (entry_bcd),
        .digit_count   (digit_count),
        .busy          (busy),
        .entry_valid   (entry_valid),
        .entry_value   (entry_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    bit   m_release;
    int   m_cand, m_run, m_rel;
    bit   exp_event;
    int   exp_code;
    int   digits[$];
    int   conv_left, conv_value;
    bit   exp_busy, exp_valid;
    int   exp_value;

    task automatic model_reset();
        m_release  = 0;
        m_cand     = 0;
        m_run      = 0;
        m_rel      = 0;
        exp_event  = 0;
        exp_code   = 0;
        digits.delete();
        conv_left  = 0;
        conv_value = 0;
        exp_busy   = 0;
        exp_valid  = 0;
        exp_value  = 0;
    endtask

    function automatic int exp_bcd();
        int v = 0;
        foreach (digits[i]) v = v * 16 + digits[i];
        return v;
    endfunction

    task automatic model_step();
        bit ev_now   = exp_event;
        int code_now = exp_code;
        exp_event = 0;
        exp_valid = 0;
        if (conv_left > 0) begin
            conv_left--;
            if (conv_left == 0) begin
                exp_valid = 1;
                exp_value = conv_value;
                digits.delete();
                exp_busy  = 0;
            end
        end else if (ev_now) begin
            if (code_now <= 9) begin
                if (digits.size() < 4) digits.push_back(code_now);
            end else if (code_now == 10) begin
                if (digits.size() > 0) void'(digits.pop_back());
            end else if (code_now == 11 && digits.size() > 0) begin
                conv_value = 0;
                foreach (digits[i]) conv_value = conv_value * 10 + digits[i];
                conv_left = digits.size();
                exp_busy  = 1;
            end
        end
        if (!m_release) begin
            if (key_pressed && key_code <= 11 && int'(key_code) == m_cand) begin
                m_run++;
                if (m_run == DB) begin
                    exp_event = 1;
                    exp_code  = m_cand;
                    m_run     = 0;
                    m_release = 1;
                    m_rel     = 0;
                end
            end else begin
                m_cand = key_code;
                m_run  = 0;
            end
        end else begin
            if (key_pressed) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel == DB) begin
                    m_release = 0;
                    m_run     = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
    end

    initial forever begin
        @(posedge reset);
        model_reset();
    end

    // Per-cycle compare and event monitors
    int         ev_count = 0, last_ev_cyc = 0, val_count = 0, val_cyc = 0, busy_cnt = 0;
    logic [3:0] last_ev_code = 0;

    initial forever begin
        @(negedge clock);
        chk("key_event", key_event, exp_event);
        chk("key_event_code", key_event_code, exp_code);
        chk("entry_bcd", entry_bcd, exp_bcd());
        chk("digit_count", digit_count, digits.size());
        chk("busy", busy, exp_busy);
        chk("entry_valid", entry_valid, exp_valid);
        chk("entry_value", entry_value, exp_value);
        if (key_event === 1'b1) begin
            ev_count++;
            last_ev_cyc  = cyc;
            last_ev_code = key_event_code;
        end
        if (entry_valid === 1'b1) begin
            val_count++;
            val_cyc = cyc;
        end
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic hold(input bit kp, input logic [3:0] kc, input int n);
        key_pressed = kp;
        key_code    = kc;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] kc);
        hold(1, kc, 8);
        hold(0, kc, 6);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        key_pressed = 1'b0;
        key_code    = 4'd0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int e0, v0, t0, n;
        bit seen;
        model_reset();
        do_reset();
        chk("rst_key_event", key_event, 0);
        chk("rst_entry_bcd", entry_bcd, 0);
        chk("rst_digit_count", digit_count, 0);
        chk("rst_busy", busy, 0);

        // Long hold gives one event; re-press needs a full release first
        e0 = ev_count;
        hold(1, 4'd5, 104);
        chk("hold_one_event", ev_count - e0, 1);
        chk("hold_event_code", last_ev_code, 4'd5);
        hold(0, 4'd5, 3);
        hold(1, 4'd5, 10);
        chk("short_release_no_event", ev_count - e0, 1);
        hold(0, 4'd5, 4);
        hold(1, 4'd5, 6);
        chk("full_release_event", ev_count - e0, 2);
        hold(0, 4'd5, 6);

        // Bounce then stable hold; invalid codes
        do_reset();
        e0 = ev_count;
        for (int i = 0; i < 5; i++) begin
            hold(1, 4'd7, 2);
            hold(0, 4'd7, 2);
        end
        chk("bounce_no_event", ev_count - e0, 0);
        t0 = cyc;
        hold(1, 4'd7, 8);
        chk("stable_one_event", ev_count - e0, 1);
        chk("stable_event_delay", last_ev_cyc - t0, 4);
        hold(0, 4'd7, 6);
        e0 = ev_count;
        for (int k = 12; k < 16; k++) hold(1, 4'(k), 8);
        hold(0, 4'd0, 6);
        chk("invalid_no_event", ev_count - e0, 0);

        // 1234#
        do_reset();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        chk("e1234_bcd", entry_bcd, 16'h1234);
        chk("e1234_count", digit_count, 4);
        busy_cnt = 0;
        v0 = val_count;
        press(4'd11);
        chk("e1234_valid_once", val_count - v0, 1);
        chk("e1234_latency", val_cyc - last_ev_cyc, 5);
        chk("e1234_busy_cycles", busy_cnt, 4);
        chk("e1234_value", entry_value, 1234);
        chk("e1234_bcd_clear", entry_bcd, 0);
        chk("e1234_count_clear", digit_count, 0);

        // 98765 * #
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
        chk("full_ignore_bcd", entry_bcd, 16'h9876);
        chk("full_ignore_count", digit_count, 4);
        press(4'd10);
        chk("star_bcd", entry_bcd, 16'h0987);
        chk("star_count", digit_count, 3);
        busy_cnt = 0;
        press(4'd11);
        chk("e987_value", entry_value, 987);
        chk("e987_latency", val_cyc - last_ev_cyc, 4);
        chk("e987_busy_cycles", busy_cnt, 3);

        // Empty '#', star on empty, leading zeros
        busy_cnt = 0;
        v0 = val_count;
        press(4'd11);
        press(4'd10);
        chk("empty_hash_busy", busy_cnt, 0);
        chk("empty_hash_valid", val_count - v0, 0);
        chk("empty_star_count", digit_count, 0);
        press(4'd0); press(4'd0); press(4'd1); press(4'd2);
        chk("lead0_count", digit_count, 4);
        chk("lead0_bcd", entry_bcd, 16'h0012);
        press(4'd11);
        chk("lead0_value", entry_value, 12);

        // Reset in the middle of a conversion
        press(4'd4); press(4'd2);
        key_pressed = 1'b1;
        key_code    = 4'd11;
        seen = 0;
        n    = 0;
        while (!seen && n < 30) begin
            @(negedge clock);
            n++;
            if (key_event === 1'b1) seen = 1;
        end
        chk("hash_event_seen", seen, 1);
        v0 = val_count;
        @(posedge clock);
        #2;
        chk("mid_convert_busy", busy, 1);
        reset       = 1'b1;
        key_pressed = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_bcd", entry_bcd, 0);
        chk("abort_count", digit_count, 0);
        chk("abort_value", entry_value, 0);
        chk("abort_code", key_event_code, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        hold(0, 4'd0, 10);
        chk("abort_no_valid", val_count - v0, 0);
        press(4'd3);
        press(4'd11);
        chk("after_abort_value", entry_value, 3);
        chk("after_abort_valid", val_count - v0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Sits directly downstream of the keypad row scanner.
- Takes the scanner's 4-bit key code plus a "some key down" flag (top level drives it as NAND of the three column lines).
- Debounces press and release, and turns each clean press into a single key event.
- Builds a multi-digit decimal entry (PIN or amount) with backspace and enter, then converts the entry to binary sequentially for the ATM controller.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable clock samples required to accept a press or a release.
- MAX_DIGITS, 4: maximum digits held in the entry buffer.
- VALUE_W, 14: width of the binary result. Must hold 10^MAX_DIGITS-1.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_code  in  4  scanner code: 0-9 digits, 10 '*', 11 '#', 12-15 invalid.
- key_pressed  in  1  high while any column is pulled low.
- key_event  out  1  one-cycle pulse per accepted, debounced press.
- key_event_code  out  4  code of the last accepted press; held until the next event.
- entry_bcd  out  4*MAX_DIGITS  entry buffer; [3:0] is the most recently entered digit.
- digit_count  out  clog2(MAX_DIGITS+1)  number of digits currently in the buffer.
- busy  out  1  high during CONVERT.
- entry_valid  out  1  one-cycle pulse when entry_value is updated.
- entry_value  out  VALUE_W  binary value of the last entered number; held until the next entry_valid.

Behaviour:
- Reset (async, immediate): all outputs 0; debouncer in WAIT_PRESS with counter 0; entry FSM in ENTRY; any conversion in progress is aborted with no entry_valid.
- A sample "qualifies" when key_pressed=1 and key_code<=11.
- Debouncer state WAIT_PRESS:
  - Holds a candidate code and a counter.
  - On a qualifying sample with code==candidate: counter+1.
  - On any other sample: candidate<=key_code, counter<=0 if qualifying, counter cleared otherwise.
  - When the counter reaches DEBOUNCE_CYCLES qualifying samples: key_event=1 for that single registered cycle, key_event_code<=candidate, counter<=0, go to WAIT_RELEASE.
- Debouncer state WAIT_RELEASE:
  - key_pressed=0: counter+1; key_pressed=1: counter<=0.
  - After DEBOUNCE_CYCLES consecutive released samples: go to WAIT_PRESS.
  - Holding a key down indefinitely gives exactly one event; there is no auto-repeat.
- Entry FSM state ENTRY, acting on key_event:
  - Digit, digit_count<MAX_DIGITS: entry_bcd<={entry_bcd shifted left 4, digit}; count+1.
  - Digit, digit_count==MAX_DIGITS: ignored, no state change.
  - Leading zeros are accepted and counted as digits.
  - '*', count>0: entry_bcd shifted right 4 with zero fill; count-1.
  - '*', count==0: ignored.
  - '#', count>0: go to CONVERT next cycle, busy=1, acc=0, idx=count-1.
  - '#', count==0: ignored; busy stays 0.
- Entry FSM state CONVERT:
  - Each cycle: acc<=acc*10 + nibble[idx]; idx-1.
  - The step that consumes nibble 0 is the last step, completing count steps.
  - The cycle after the last step: entry_valid=1, entry_value<=acc, entry_bcd<=0, digit_count<=0, busy<=0, return to ENTRY.
  - Latency: entry_valid rises count+1 cycles after the '#' key_event cycle.
- The debouncer keeps running during CONVERT. key_event still pulses, but the entry FSM drops those events.
- Arithmetic: acc is VALUE_W bits; the multiply-by-10 is done as (acc<<3)+(acc<<1). Overflow is impossible under the parameter rule.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and MAX_DIGITS=4 for all scenarios.
- Key '5' held 104 cycles, then released -> exactly one key_event with key_event_code=5; no further event; a new press is accepted only after 4 released cycles.
- key_pressed toggles every 2 cycles for 20 cycles with code 7, then held stable -> no event during the bounce; one event 4 cycles into the stable hold. Codes 12-15 held high -> no event.
- Keys 1,2,3,4 then '#' -> entry_bcd=0x1234, digit_count=4 before '#'; busy high 4 cycles; entry_valid pulse 5 cycles after the '#' event with entry_value=1234; entry_bcd and digit_count clear to 0.
- Keys 9,8,7,6,5 -> 5 ignored, entry_bcd=0x9876; '*' -> entry_bcd=0x0987, digit_count=3; '#' -> entry_value=987.
- '#' on an empty buffer -> no busy, no entry_valid. Keys 0,0,1,2,'#' -> digit_count=4, entry_value=12.
- Keys 4,2,'#', then reset asserted mid-CONVERT -> all outputs 0 immediately; no entry_valid; after reset release the next entry behaves normally.
